dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the memory-stage load/store interface (sw/sh/sb, lw/lh/lb, address, write data).
- Accepts one request at a time over a valid/ready handshake and waits a configurable latency before accessing a little-endian byte-lane RAM.
- Returns load data with sign extension and drives a stall signal so the pipeline can freeze.

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory-stage load/store port.
// Accepts one request at a time, waits LATENCY busy cycles, then performs a
// little-endian byte-lane access and returns a sign-extended load result.
//
// state | meaning
// IDLE  | ready for a request; handshake captures it and starts the timer
// BUSY  | latency timer counting down; access happens when it reaches 0
// RESP  | one-cycle response (resp_valid=1), then back to IDLE
module dmem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  sw,
    input  logic                  sh,
    input  logic                  sb,
    input  logic                  lw,
    input  logic                  lh,
    input  logic                  lb,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  resp_valid,
    output logic                  err,
    output logic                  stall
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    // strobe order: {sw, sh, sb, lw, lh, lb}
    logic [5:0]              cap_op;

    logic [DATA_WIDTH-1:0]   mem [WORDS];

    logic [5:0]              req_op;
    logic                    handshake;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [1:0]              lane;
    logic                    op_err;
    logic                    is_store;
    logic [3:0]              byte_en;
    logic [31:0]             wr_data;
    logic [31:0]             rd_word;
    logic [31:0]             rd_shift;
    logic [31:0]             load_data;
    logic                    access;
    logic                    unused_addr_bits;

    assign req_op           = {sw, sh, sb, lw, lh, lb};
    assign req_ready        = (state == IDLE);
    assign handshake        = req_ready && req_valid && (|req_op);
    assign stall            = handshake || (state == BUSY);
    assign access           = (state == BUSY) && (cnt == 4'd0);
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    assign word_idx = cap_addr[ADDR_WIDTH-1:2];
    assign lane     = cap_addr[1:0];
    assign rd_word  = mem[word_idx];

    // Decode the captured request: legality, byte enables, store data and load result.
    always_comb begin
        op_err    = 1'b0;
        is_store  = |cap_op[5:3];
        byte_en   = 4'b0000;
        wr_data   = cap_wdata;
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = 32'd0;

        // more than one strobe set is illegal
        if ((cap_op & (cap_op - 6'd1)) != 6'd0)
            op_err = 1'b1;
        if ((cap_op[5] || cap_op[2]) && (lane != 2'b00))
            op_err = 1'b1;
        if ((cap_op[4] || cap_op[1]) && lane[0])
            op_err = 1'b1;

        if (cap_op[5]) begin
            byte_en = 4'b1111;
            wr_data = cap_wdata;
        end else if (cap_op[4]) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{cap_wdata[15:0]}};
        end else if (cap_op[3]) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{cap_wdata[7:0]}};
        end

        if (cap_op[2])
            load_data = rd_word;
        else if (cap_op[1])
            load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        else if (cap_op[0])
            load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
    end

    // Request FSM with latency timer and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_op     <= '0;
            rdata      <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cap_addr  <= addr[ADDR_WIDTH-1:0];
                        cap_wdata <= wdata;
                        cap_op    <= req_op;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err        <= op_err;
                        rdata      <= (op_err || is_store) ? 32'd0 : load_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM write at the BUSY->RESP edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && is_store && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with hand-computed expected values.
module tb_dmem_responder;

    localparam int LAT = 2;

    localparam logic [5:0] OP_SW   = 6'b100000;
    localparam logic [5:0] OP_SH   = 6'b010000;
    localparam logic [5:0] OP_SB   = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_LH   = 6'b000010;
    localparam logic [5:0] OP_LB   = 6'b000001;
    localparam logic [5:0] OP_NONE = 6'b000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        sw = 1'b0, sh = 1'b0, sb = 1'b0, lw = 1'b0, lh = 1'b0, lb = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        err;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .sw         (sw),
        .sh         (sh),
        .sb         (sb),
        .lw         (lw),
        .lh         (lh),
        .lb         (lb),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .err        (err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        {sw, sh, sb, lw, lh, lb} = op;
        addr      = a;
        wdata     = d;
        req_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        {sw, sh, sb, lw, lh, lb} = OP_NONE;
        req_valid = 1'b0;
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic do_req(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e);
        int   n;
        logic stall_ok;
        drive(op, a, d);
        #1;
        chk({tag, "_stall_T"}, 32'(stall), 32'd1);
        @(negedge clk);
        idle_inputs();
        n = 1;
        stall_ok = 1'b1;
        while (!resp_valid && n < 20) begin
            if (!stall || req_ready) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_stall"}, 32'(stall_ok), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
        rd = rdata;
        e  = err;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          pulses;
    int          readies;
    int          bad;

    initial begin
        // reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // word round trip
        do_req("sw100", OP_SW, 32'h100, 32'hDEADBEEF, rd, e);
        chk("sw100_err", 32'(e), 32'd0);
        chk("sw100_rdata", rd, 32'd0);
        do_req("lw100", OP_LW, 32'h100, 32'h0, rd, e);
        chk("lw100_rdata", rd, 32'hDEADBEEF);
        chk("lw100_err", 32'(e), 32'd0);

        // byte / half lanes
        do_req("sw200", OP_SW, 32'h200, 32'h0, rd, e);
        do_req("sb202", OP_SB, 32'h202, 32'hFFFFFF80, rd, e);
        chk("sb202_err", 32'(e), 32'd0);
        do_req("sh200", OP_SH, 32'h200, 32'hAAAA7FFF, rd, e);
        chk("sh200_err", 32'(e), 32'd0);
        do_req("lw200", OP_LW, 32'h200, 32'h0, rd, e);
        chk("lw200_rdata", rd, 32'h00807FFF);
        do_req("lb202", OP_LB, 32'h202, 32'h0, rd, e);
        chk("lb202_rdata", rd, 32'hFFFFFF80);
        do_req("lh200", OP_LH, 32'h200, 32'h0, rd, e);
        chk("lh200_rdata", rd, 32'h00007FFF);
        do_req("lh202", OP_LH, 32'h202, 32'h0, rd, e);
        chk("lh202_rdata", rd, 32'h00000080);
        do_req("lb201", OP_LB, 32'h201, 32'h0, rd, e);
        chk("lb201_rdata", rd, 32'h0000007F);
        do_req("lb103", OP_LB, 32'h103, 32'h0, rd, e);
        chk("lb103_rdata", rd, 32'hFFFFFFDE);
        do_req("lh102", OP_LH, 32'h102, 32'h0, rd, e);
        chk("lh102_rdata", rd, 32'hFFFFDEAD);

        // misaligned and illegal
        do_req("lw102", OP_LW, 32'h102, 32'h0, rd, e);
        chk("lw102_err", 32'(e), 32'd1);
        chk("lw102_rdata", rd, 32'd0);
        do_req("sh101", OP_SH, 32'h101, 32'h00001234, rd, e);
        chk("sh101_err", 32'(e), 32'd1);
        do_req("lwsw", OP_LW | OP_SW, 32'h100, 32'h11111111, rd, e);
        chk("lwsw_err", 32'(e), 32'd1);
        chk("lwsw_rdata", rd, 32'd0);
        do_req("lw100b", OP_LW, 32'h100, 32'h0, rd, e);
        chk("lw100b_err", 32'(e), 32'd0);
        chk("lw100b_unchanged", rd, 32'hDEADBEEF);

        // req_valid without strobes is ignored
        drive(OP_NONE, 32'h100, 32'h0);
        #1;
        chk("nostrobe_stall", 32'(stall), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!req_ready || resp_valid || stall) bad++;
        end
        chk("nostrobe_idle", 32'(bad), 32'd0);
        idle_inputs();

        // req_valid held high: accepted only in IDLE, one response per LAT+2 cycles
        drive(OP_LW, 32'h200, 32'h0);
        pulses  = 0;
        readies = 0;
        for (int i = 0; i < 4 * (LAT + 2); i++) begin
            #1;
            if (resp_valid) pulses++;
            if (req_ready) readies++;
            @(negedge clk);
        end
        chk("held_pulses", 32'(pulses), 32'd4);
        chk("held_accepts", 32'(readies), 32'd4);
        idle_inputs();
        @(negedge clk);
        chk("held_rdata", rdata, 32'h00807FFF);

        // reset during BUSY discards the pending store
        do_req("sw300", OP_SW, 32'h300, 32'hCAFEF00D, rd, e);
        drive(OP_SW, 32'h300, 32'h12345678);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(req_ready), 32'd1);
        pulses = 0;
        @(negedge clk);
        if (resp_valid) pulses++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("midrst_noresp", 32'(pulses), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        do_req("lw300", OP_LW, 32'h300, 32'h0, rd, e);
        chk("lw300_rdata", rd, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
